// File: rtl/plic_pkg.sv
// Constants shared by the PLIC arbitration slice.
// Holds the FSM state encoding, default widths and the reserved claim ID.
package plic_pkg;

    localparam int INT_NUM_DEF  = 32;
    localparam int ID_NUM_DEF   = 5;
    localparam int PRIO_BIT_DEF = 5;
    localparam int SCAN_W_DEF   = 8;

    // Claim ID 0 means "no interrupt" and is never granted.
    localparam int RSVD_ID = 0;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_SCAN = 2'b01,
        ARB_DONE = 2'b10
    } arb_state_e;

endpackage

// File: rtl/plic_kid_arb_scan_if.sv
// Links the kid stages and the hart register block to the arbiter.
// The hart side drives through the master modport; the arbiter uses slave.
interface plic_kid_arb_scan_if
    import plic_pkg::*;
#(
    parameter int INT_NUM  = INT_NUM_DEF,
    parameter int ID_NUM   = ID_NUM_DEF,
    parameter int PRIO_BIT = PRIO_BIT_DEF
);

    logic [INT_NUM-1:0]          kid_arb_int_req;
    logic [INT_NUM*PRIO_BIT-1:0] kid_arb_int_prio;
    logic [INT_NUM-1:0]          kid_arb_int_pulse;
    logic [INT_NUM-1:0]          hreg_arb_ie;
    logic [PRIO_BIT-1:0]         hreg_arb_threshold;
    logic                        hreg_arb_claim;
    logic                        hreg_arb_update;
    logic [ID_NUM-1:0]           arb_hreg_claim_id;
    logic [PRIO_BIT-1:0]         arb_hreg_claim_prio;
    logic                        arb_ctrl_int_vld;
    logic                        arb_busy;

    modport master (
        output kid_arb_int_req, kid_arb_int_prio, kid_arb_int_pulse,
        output hreg_arb_ie, hreg_arb_threshold, hreg_arb_claim, hreg_arb_update,
        input  arb_hreg_claim_id, arb_hreg_claim_prio, arb_ctrl_int_vld, arb_busy
    );

    modport slave (
        input  kid_arb_int_req, kid_arb_int_prio, kid_arb_int_pulse,
        input  hreg_arb_ie, hreg_arb_threshold, hreg_arb_claim, hreg_arb_update,
        output arb_hreg_claim_id, arb_hreg_claim_prio, arb_ctrl_int_vld, arb_busy
    );

endinterface

// File: rtl/plic_arb_grp_cmp.sv
// Combinational compare across one scan group.
// Returns the highest-priority candidate; ties go to the lowest index.
module plic_arb_grp_cmp #(
    parameter int SCAN_W   = 8,
    parameter int PRIO_BIT = 5,
    parameter int IDX_W    = $clog2(SCAN_W)
) (
    input  logic [SCAN_W-1:0]          i_cand,
    input  logic [SCAN_W*PRIO_BIT-1:0] i_prio,
    output logic [IDX_W-1:0]           o_idx,
    output logic [PRIO_BIT-1:0]        o_prio,
    output logic                       o_found
);

    // NOTE: every output gets a default before the loop, so no latch can be inferred.
    always_comb begin
        o_idx   = '0;
        o_prio  = '0;
        o_found = 1'b0;
        for (int j = 0; j < SCAN_W; j++) begin
            // The strict compare keeps the earlier (lower) index on a tie.
            if (i_cand[j] && (!o_found || (i_prio[j*PRIO_BIT +: PRIO_BIT] > o_prio))) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(j);
                o_prio  = i_prio[j*PRIO_BIT +: PRIO_BIT];
            end
        end
    end

endmodule

// File: rtl/plic_kid_arb_scan.sv
// Grouped multi-cycle scan for the highest-priority enabled pending source.
// Publishes the winning claim ID and priority to the hart, and rescans on every trigger.
module plic_kid_arb_scan
    import plic_pkg::*;
#(
    parameter int INT_NUM  = INT_NUM_DEF,
    parameter int ID_NUM   = ID_NUM_DEF,
    parameter int PRIO_BIT = PRIO_BIT_DEF,
    parameter int SCAN_W   = SCAN_W_DEF
) (
    input  logic                 kid_clk,
    input  logic                 plicrst_b,
    plic_kid_arb_scan_if.slave   bus
);

    localparam int GRP_NUM = INT_NUM / SCAN_W;
    localparam int GRP_W   = (GRP_NUM > 1) ? $clog2(GRP_NUM) : 1;
    localparam int SCAN_LG = $clog2(SCAN_W);

    arb_state_e                 r_state, w_state_nxt;
    logic [GRP_W-1:0]           r_grp;
    logic [ID_NUM-1:0]          r_best_id, r_claim_id;
    logic [PRIO_BIT-1:0]        r_best_prio, r_claim_prio;
    logic                       r_retrig, r_supp, r_int_vld;

    logic                       w_trig, w_last, w_take;
    logic [INT_NUM-1:0]         w_cand;
    logic [SCAN_W-1:0]          w_grp_cand;
    logic [SCAN_W*PRIO_BIT-1:0] w_grp_prio_flat;
    logic [SCAN_LG-1:0]         w_grp_idx;
    logic [PRIO_BIT-1:0]        w_grp_prio, w_best_prio_nxt;
    logic                       w_grp_found;
    logic [ID_NUM-1:0]          w_grp_id, w_best_id_nxt;

    assign w_trig = (|bus.kid_arb_int_pulse) | bus.hreg_arb_update | bus.hreg_arb_claim;
    assign w_last = (r_grp == GRP_W'(GRP_NUM - 1));

    always_comb begin
        w_cand = '0;
        for (int i = RSVD_ID + 1; i < INT_NUM; i++) begin
            w_cand[i] = bus.kid_arb_int_req[i] & bus.hreg_arb_ie[i] &
                        (bus.kid_arb_int_prio[i*PRIO_BIT +: PRIO_BIT] > bus.hreg_arb_threshold);
        end
    end

    // Inputs are read live, so a source that changes mid-scan is seen if its group is still ahead.
    always_comb begin
        w_grp_cand      = '0;
        w_grp_prio_flat = '0;
        for (int g = 0; g < GRP_NUM; g++) begin
            if (r_grp == GRP_W'(g)) begin
                w_grp_cand      = w_cand[g*SCAN_W +: SCAN_W];
                w_grp_prio_flat = bus.kid_arb_int_prio[g*SCAN_W*PRIO_BIT +: SCAN_W*PRIO_BIT];
            end
        end
    end

    plic_arb_grp_cmp #(
        .SCAN_W   (SCAN_W),
        .PRIO_BIT (PRIO_BIT),
        .IDX_W    (SCAN_LG)
    ) u_grp_cmp (
        .i_cand  (w_grp_cand),
        .i_prio  (w_grp_prio_flat),
        .o_idx   (w_grp_idx),
        .o_prio  (w_grp_prio),
        .o_found (w_grp_found)
    );

    // Groups are visited in ascending order, so a strict compare keeps the lowest ID on a tie.
    assign w_grp_id        = {r_grp, w_grp_idx};
    assign w_take          = w_grp_found && (w_grp_prio > r_best_prio);
    assign w_best_id_nxt   = w_take ? w_grp_id   : r_best_id;
    assign w_best_prio_nxt = w_take ? w_grp_prio : r_best_prio;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge kid_clk or negedge plicrst_b) begin
        if (!plicrst_b) r_state <= ARB_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: if (w_trig) w_state_nxt = ARB_SCAN;
            ARB_SCAN: if (w_last) w_state_nxt = ARB_DONE;
            ARB_DONE: w_state_nxt = (r_retrig || w_trig) ? ARB_SCAN : ARB_IDLE;
            default:  w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge kid_clk or negedge plicrst_b) begin
        if (!plicrst_b) begin
            r_grp        <= '0;
            r_best_id    <= ID_NUM'(RSVD_ID);
            r_best_prio  <= '0;
            r_retrig     <= 1'b0;
            r_supp       <= 1'b0;
            r_claim_id   <= ID_NUM'(RSVD_ID);
            r_claim_prio <= '0;
            r_int_vld    <= 1'b0;
        end else begin
            if (r_state == ARB_SCAN) begin
                r_grp       <= r_grp + GRP_W'(1);
                r_best_id   <= w_best_id_nxt;
                r_best_prio <= w_best_prio_nxt;
                if (w_trig) r_retrig <= 1'b1;
                // A claim mid-scan voids this scan's result; the retrigger rescans afterwards.
                if (w_last)                   r_supp <= 1'b0;
                else if (bus.hreg_arb_claim)  r_supp <= 1'b1;
            end else begin
                r_grp       <= '0;
                r_best_id   <= ID_NUM'(RSVD_ID);
                r_best_prio <= '0;
                if (r_state == ARB_DONE) r_retrig <= 1'b0;
            end

            if (bus.hreg_arb_claim) begin
                r_claim_id   <= ID_NUM'(RSVD_ID);
                r_claim_prio <= '0;
                r_int_vld    <= 1'b0;
            end else if ((r_state == ARB_SCAN) && w_last && !r_supp) begin
                r_claim_id   <= w_best_id_nxt;
                r_claim_prio <= w_best_prio_nxt;
                r_int_vld    <= (w_best_id_nxt != ID_NUM'(RSVD_ID));
            end
        end
    end

    assign bus.arb_hreg_claim_id   = r_claim_id;
    assign bus.arb_hreg_claim_prio = r_claim_prio;
    assign bus.arb_ctrl_int_vld    = r_int_vld;
    assign bus.arb_busy            = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_plic_kid_arb_scan.sv
// Scoreboard bench for plic_kid_arb_scan: directed plus random stimulus.
// Expected results come from a flat whole-array reference model; a monitor checks each busy window.
module tb_plic_kid_arb_scan;

    localparam int N  = 32;
    localparam int PB = 5;
    localparam int IB = 5;

    typedef struct {
        logic [IB-1:0] id;
        logic [PB-1:0] prio;
        logic          vld;
        int            len;
    } exp_t;

    logic kid_clk   = 1'b0;
    logic plicrst_b = 1'b0;

    plic_kid_arb_scan_if #(.INT_NUM(N), .ID_NUM(IB), .PRIO_BIT(PB)) bus ();

    plic_kid_arb_scan #(.INT_NUM(N), .ID_NUM(IB), .PRIO_BIT(PB), .SCAN_W(8)) dut (
        .kid_clk   (kid_clk),
        .plicrst_b (plicrst_b),
        .bus       (bus)
    );

    always #5 kid_clk = ~kid_clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    int   run_len  = 0;

    bit m_req [N];
    bit m_ie  [N];
    int m_prio[N];
    int m_thr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit is_cand(input int i);
        return (i != 0) && m_req[i] && m_ie[i] && (m_prio[i] > m_thr);
    endfunction

    // Reference: find the top candidate priority, then the smallest ID holding it.
    function automatic exp_t model(input int len);
        exp_t e;
        int   top = -1;
        e.id = '0; e.prio = '0; e.vld = 1'b0; e.len = len;
        for (int i = 0; i < N; i++)
            if (is_cand(i) && m_prio[i] > top) top = m_prio[i];
        for (int i = N - 1; i >= 0; i--)
            if (is_cand(i) && m_prio[i] == top) begin
                e.id = IB'(i); e.prio = PB'(m_prio[i]); e.vld = 1'b1;
            end
        return e;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            m_req[i] = 1'b0; m_ie[i] = 1'b0; m_prio[i] = 0;
        end
        m_thr = 0;
    endtask

    task automatic set_src(input int s, input int p);
        m_req[s] = 1'b1; m_ie[s] = 1'b1; m_prio[s] = p;
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.kid_arb_int_req[i]           = m_req[i];
            bus.hreg_arb_ie[i]               = m_ie[i];
            bus.kid_arb_int_prio[i*PB +: PB] = PB'(m_prio[i]);
        end
        bus.hreg_arb_threshold = PB'(m_thr);
    endtask

    // kind: 0 = update strobe, 1 = pulse on source s, 2 = claim strobe
    task automatic strobe(input int kind, input int s);
        @(posedge kid_clk); #1;
        apply();
        case (kind)
            0:       bus.hreg_arb_update = 1'b1;
            1:       bus.kid_arb_int_pulse[s] = 1'b1;
            default: bus.hreg_arb_claim = 1'b1;
        endcase
        @(posedge kid_clk); #1;
        bus.hreg_arb_update   = 1'b0;
        bus.hreg_arb_claim    = 1'b0;
        bus.kid_arb_int_pulse = '0;
    endtask

    task automatic push_exp(input int len);
        exp_q.push_back(model(len));
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge kid_clk);
        while (bus.arb_busy && n < 100) begin
            @(negedge kid_clk);
            n++;
        end
        check("idle_timeout", 32'(bus.arb_busy), 32'd0);
        @(negedge kid_clk);
    endtask

    task automatic txn(input int kind, input int s);
        push_exp(5);
        strobe(kind, s);
        wait_idle();
    endtask

    // Monitor: a publish is complete when a busy window closes.
    always @(negedge kid_clk) begin
        if (!plicrst_b) begin
            run_len = 0;
        end else if (bus.arb_busy) begin
            run_len++;
        end else if (run_len > 0) begin
            check("sb_expected_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_claim_id",   32'(bus.arb_hreg_claim_id),   32'(e.id));
                check("sb_claim_prio", 32'(bus.arb_hreg_claim_prio), 32'(e.prio));
                check("sb_int_vld",    32'(bus.arb_ctrl_int_vld),    32'(e.vld));
                check("sb_busy_len",   32'(run_len),                 32'(e.len));
            end
            run_len = 0;
        end
    end

    initial begin
        bus.kid_arb_int_req    = '0;
        bus.kid_arb_int_prio   = '0;
        bus.kid_arb_int_pulse  = '0;
        bus.hreg_arb_ie        = '0;
        bus.hreg_arb_threshold = '0;
        bus.hreg_arb_claim     = 1'b0;
        bus.hreg_arb_update    = 1'b0;
        clear_model();

        repeat (3) @(negedge kid_clk);
        check("rst_claim_id",   32'(bus.arb_hreg_claim_id),   32'd0);
        check("rst_claim_prio", 32'(bus.arb_hreg_claim_prio), 32'd0);
        check("rst_int_vld",    32'(bus.arb_ctrl_int_vld),    32'd0);
        check("rst_busy",       32'(bus.arb_busy),            32'd0);
        @(posedge kid_clk); #1 plicrst_b = 1'b1;

        // Single source above threshold.
        clear_model(); m_thr = 2; set_src(3, 5);
        txn(1, 3);

        // Equal priority across groups resolves to the lowest ID.
        clear_model(); set_src(4, 7); set_src(20, 7); set_src(9, 6);
        txn(0, 0);

        // Priority equal to threshold is excluded; lowering the threshold admits it.
        clear_model(); m_thr = 3; set_src(6, 3); set_src(12, 3);
        txn(0, 0);
        m_thr = 2;
        txn(0, 0);

        // Claim clears outputs on the next edge; the rescan sees src 6 gone.
        m_req[6] = 1'b0;
        push_exp(5);
        strobe(2, 0);
        @(negedge kid_clk);
        check("claim_clear_id",  32'(bus.arb_hreg_claim_id), 32'd0);
        check("claim_clear_vld", 32'(bus.arb_ctrl_int_vld),  32'd0);
        wait_idle();

        // New pulse during scan group 1 forces exactly one extra scan.
        clear_model(); m_thr = 2; set_src(5, 4);
        strobe(0, 0);
        set_src(30, 9);
        push_exp(10);
        strobe(1, 30);
        wait_idle();

        // Claim during a scan: outputs clear at once and a full rescan follows.
        push_exp(10);
        strobe(0, 0);
        strobe(2, 0);
        @(negedge kid_clk);
        check("scan_claim_id",  32'(bus.arb_hreg_claim_id), 32'd0);
        check("scan_claim_vld", 32'(bus.arb_ctrl_int_vld),  32'd0);
        wait_idle();

        // Randomized source sets.
        for (int k = 0; k < 20; k++) begin
            clear_model();
            m_thr = int'($urandom_range(0, 6));
            for (int i = 0; i < N; i++) begin
                m_req[i]  = ($urandom_range(0, 3) == 0);
                m_ie[i]   = ($urandom_range(0, 3) != 0);
                m_prio[i] = int'($urandom_range(0, 31));
            end
            txn(0, 0);
        end

        // Reserved ID 0 is never selected even at maximum priority.
        clear_model(); set_src(0, 31);
        txn(1, 0);

        // Reset mid-scan drops the published result and returns to idle.
        clear_model(); m_thr = 2; set_src(3, 5);
        txn(0, 0);
        strobe(0, 0);
        @(posedge kid_clk); #1 plicrst_b = 1'b0;
        @(negedge kid_clk);
        check("arst_claim_id",   32'(bus.arb_hreg_claim_id),   32'd0);
        check("arst_claim_prio", 32'(bus.arb_hreg_claim_prio), 32'd0);
        check("arst_int_vld",    32'(bus.arb_ctrl_int_vld),    32'd0);
        check("arst_busy",       32'(bus.arb_busy),            32'd0);
        @(posedge kid_clk); #1 plicrst_b = 1'b1;
        repeat (8) @(negedge kid_clk);
        check("arst_stays_idle", 32'(bus.arb_busy), 32'd0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
